// File: rtl/srec_pkg.sv
// Shared constants for the S-record loader: FSM state encodings, error codes,
// ASCII control characters and record-type helpers.
package srec_pkg;

  // FSM state encodings
  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StType  = 4'd1;
  localparam logic [3:0] StCntHi = 4'd2;
  localparam logic [3:0] StCntLo = 4'd3;
  localparam logic [3:0] StAddr  = 4'd4;
  localparam logic [3:0] StData  = 4'd5;
  localparam logic [3:0] StCsum  = 4'd6;
  localparam logic [3:0] StEol   = 4'd7;
  localparam logic [3:0] StWr    = 4'd8;
  localparam logic [3:0] StDone  = 4'd9;
  localparam logic [3:0] StErr   = 4'd10;

  // err_code values
  localparam logic [2:0] ErrNone = 3'd0;
  localparam logic [2:0] ErrHex  = 3'd1;
  localparam logic [2:0] ErrType = 3'd2;
  localparam logic [2:0] ErrLen  = 3'd3;
  localparam logic [2:0] ErrCsum = 3'd4;
  localparam logic [2:0] ErrEol  = 3'd5;

  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChSp = 8'h20;
  localparam logic [7:0] ChS  = 8'h53;

  // Address field length in bytes for a record type
  function automatic logic [2:0] addr_len(input logic [3:0] t);
    case (t)
      4'd2, 4'd6, 4'd8: addr_len = 3'd3;
      4'd3, 4'd7:       addr_len = 3'd4;
      default:          addr_len = 3'd2;
    endcase
  endfunction

  function automatic logic is_data_rec(input logic [3:0] t);
    is_data_rec = (t >= 4'd1) && (t <= 4'd3);
  endfunction

  function automatic logic is_term_rec(input logic [3:0] t);
    is_term_rec = (t >= 4'd7) && (t <= 4'd9);
  endfunction

endpackage

// File: rtl/srec_loader_if.sv
// Character-stream and memory-write bus of the S-record loader.
//  char_in/char_valid/char_ready : ASCII input stream (transfer = valid & ready)
//  mem_addr/mem_data/mem_wr      : byte write request, held until mem_wr_ready
// master = the loader, slave = the character source and memory.
interface srec_loader_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_wr;
  logic              mem_wr_ready;

  modport master (
    input  char_in, char_valid, mem_wr_ready,
    output char_ready, mem_addr, mem_data, mem_wr
  );

  modport slave (
    output char_in, char_valid, mem_wr_ready,
    input  char_ready, mem_addr, mem_data, mem_wr
  );
endinterface

// File: rtl/srec_hex_decode.sv
// Combinational ASCII-to-nibble decoder.
//  ch     : ASCII character
//  nib    : nibble value (0 when not hex)
//  is_hex : ch is one of 0-9, A-F, a-f
module srec_hex_decode (
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       is_hex
);
  always_comb begin
    nib    = 4'd0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib    = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10
      nib    = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end
endmodule

// File: rtl/srec_loader.sv
// Motorola S-record loader: parses an ASCII stream, writes S1/S2/S3 data bytes
// to memory, verifies record checksums and captures the S7/S8/S9 entry address.
//  clk, rst   : clock, synchronous active-high reset
//  bus        : character input and memory write port (master side)
//  busy       : a record is being parsed (TYPE..EOL, including WR)
//  done/err   : sticky completion / fault flags; err_code holds the first fault
//  entry_addr : address from the termination record
//  rec_count  : data records accepted with a good checksum (saturating)
// ADDR_W must not exceed 32 (record addresses are at most 4 bytes).
module srec_loader
  import srec_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_DATA = 255,
  parameter int unsigned ALLOW_S0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  srec_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [ADDR_W-1:0] entry_addr,
  output logic [15:0]       rec_count
);
  logic [3:0]        state_q, state_d, type_q, type_d, nib_hi_q, nib_hi_d, nib;
  logic              hi_q, hi_d, is_hex, xfer, is_eol, fault;
  logic [7:0]        cnt_q, cnt_d, left_q, left_d, sum_q, sum_d, byte_val, sum_nxt, dlen;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [2:0]        alen_q, alen_d, err_code_q, err_code_d, fault_code;
  logic [31:0]       rec_addr_q, rec_addr_d;
  logic [ADDR_W-1:0] offset_q, offset_d, mem_addr_q, mem_addr_d, entry_q, entry_d;
  logic              mem_wr_q, mem_wr_d, done_q, done_d, err_q, err_d;
  logic [15:0]       rec_count_q, rec_count_d;

  srec_hex_decode u_hex (
    .ch     (bus.char_in),
    .nib    (nib),
    .is_hex (is_hex)
  );

  assign xfer     = bus.char_valid & bus.char_ready;
  assign is_eol   = (bus.char_in == ChCr) || (bus.char_in == ChLf);
  assign byte_val = {nib_hi_q, nib};
  assign sum_nxt  = sum_q + byte_val;
  assign dlen     = cnt_q - {5'd0, alen_q} - 8'd1;

  always_comb begin
    state_d     = state_q;     hi_d        = hi_q;        nib_hi_d   = nib_hi_q;
    type_d      = type_q;      cnt_d       = cnt_q;       alen_d     = alen_q;
    left_d      = left_q;      rec_addr_d  = rec_addr_q;  offset_d   = offset_q;
    sum_d       = sum_q;       mem_addr_d  = mem_addr_q;  mem_data_d = mem_data_q;
    mem_wr_d    = mem_wr_q;    done_d      = done_q;      err_d      = err_q;
    err_code_d  = err_code_q;  entry_d     = entry_q;     rec_count_d = rec_count_q;
    fault       = 1'b0;
    fault_code  = ErrNone;

    if (state_q == StWr) begin
      if (bus.mem_wr_ready) begin
        mem_wr_d = 1'b0;
        offset_d = offset_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_d  = (left_q == 8'd0) ? StCsum : StData;
      end
    end else if (xfer) begin
      case (state_q)
        StIdle: begin
          if (bus.char_in == ChS) begin
            state_d    = StType;
            sum_d      = 8'd0;
            hi_d       = 1'b0;
            offset_d   = '0;
            rec_addr_d = 32'd0;
          end else if (!is_eol && bus.char_in != ChSp) begin
            fault = 1'b1; fault_code = ErrHex;
          end
        end
        StType: begin
          if (is_eol) begin
            fault = 1'b1; fault_code = ErrEol;
          end else if (bus.char_in < 8'h30 || bus.char_in > 8'h39 || bus.char_in == 8'h34 ||
                       (bus.char_in == 8'h30 && ALLOW_S0 == 0)) begin
            fault = 1'b1; fault_code = ErrType;
          end else begin
            type_d  = bus.char_in[3:0];
            alen_d  = addr_len(bus.char_in[3:0]);
            state_d = StCntHi;
          end
        end
        StCntHi, StCntLo, StAddr, StData, StCsum: begin
          if (is_eol) begin
            fault = 1'b1; fault_code = ErrEol;
          end else if (!is_hex) begin
            fault = 1'b1; fault_code = ErrHex;
          end else if (state_q == StCntHi) begin
            nib_hi_d = nib;
            state_d  = StCntLo;
          end else if (state_q == StCntLo) begin
            cnt_d  = byte_val;
            sum_d  = sum_nxt;
            left_d = {5'd0, alen_q};
            if (byte_val < ({5'd0, alen_q} + 8'd1) || 32'(byte_val) > MAX_DATA) begin
              fault = 1'b1; fault_code = ErrLen;
            end else begin
              state_d = StAddr;
            end
          end else if (!hi_q) begin
            nib_hi_d = nib;
            hi_d     = 1'b1;
          end else begin
            hi_d  = 1'b0;
            sum_d = sum_nxt;
            if (state_q == StAddr) begin
              rec_addr_d = {rec_addr_q[23:0], byte_val};
              left_d     = left_q - 8'd1;
              if (left_q == 8'd1) begin
                left_d  = dlen;
                state_d = (dlen == 8'd0) ? StCsum : StData;
              end
            end else if (state_q == StData) begin
              left_d = left_q - 8'd1;
              if (is_data_rec(type_q)) begin
                mem_addr_d = rec_addr_q[ADDR_W-1:0] + offset_q;
                mem_data_d = byte_val;
                mem_wr_d   = 1'b1;
                state_d    = StWr;
              end else if (left_q == 8'd1) begin
                state_d = StCsum;
              end
            end else if (sum_nxt != 8'hFF) begin
              fault = 1'b1; fault_code = ErrCsum;
            end else if (is_term_rec(type_q)) begin
              entry_d = rec_addr_q[ADDR_W-1:0];
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              if (is_data_rec(type_q) && rec_count_q != 16'hFFFF) begin
                rec_count_d = rec_count_q + 16'd1;
              end
              state_d = StEol;
            end
          end
        end
        StEol: begin
          if (bus.char_in == ChLf) begin
            state_d = StIdle;
          end else if (bus.char_in != ChCr) begin
            fault = 1'b1; fault_code = ErrEol;
          end
        end
        default: ;  // StDone / StErr drain input
      endcase
    end

    if (fault) begin
      state_d = StErr;
      err_d   = 1'b1;
      if (!err_q) err_code_d = fault_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;  hi_q <= 1'b0;   nib_hi_q <= 4'd0;  type_q <= 4'd0;
      cnt_q <= 8'd0;      alen_q <= 3'd0; left_q <= 8'd0;    rec_addr_q <= 32'd0;
      offset_q <= '0;     sum_q <= 8'd0;  mem_addr_q <= '0;  mem_data_q <= 8'd0;
      mem_wr_q <= 1'b0;   done_q <= 1'b0; err_q <= 1'b0;     err_code_q <= ErrNone;
      entry_q <= '0;      rec_count_q <= 16'd0;
    end else begin
      state_q <= state_d;    hi_q <= hi_d;      nib_hi_q <= nib_hi_d;  type_q <= type_d;
      cnt_q <= cnt_d;        alen_q <= alen_d;  left_q <= left_d;      rec_addr_q <= rec_addr_d;
      offset_q <= offset_d;  sum_q <= sum_d;    mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;  mem_wr_q <= mem_wr_d;  done_q <= done_d;  err_q <= err_d;
      err_code_q <= err_code_d;  entry_q <= entry_d;    rec_count_q <= rec_count_d;
    end
  end

  assign bus.char_ready = (state_q != StWr);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_wr     = mem_wr_q;
  assign busy           = ((state_q >= StType) && (state_q <= StEol)) || (state_q == StWr);
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;
  assign entry_addr     = entry_q;
  assign rec_count      = rec_count_q;
endmodule
